// File: rtl/ball_engine.sv
// ball_engine: pong ball motion, wall/paddle collision, hit/miss counting
// and a registered per-pixel ball flag for the colour mux.
// Optional feature macro: BALL_SPEEDUP_EN (step grows by 1 every 4th paddle
// hit, capped at 8, back to STEP0 on every serve). Undefined: constant step.
//
// Handshake note: there is no valid/ready pair here. frame_tick acts as a
// one-cycle qualifier; motion, collision and pad_y sampling happen only in
// that cycle, and every registered result appears one vga_clk edge later.
module ball_engine #(
  parameter int H_MAX      = 640,
  parameter int V_MAX      = 480,
  parameter int BALL_SZ    = 8,
  parameter int STEP0      = 4,
  parameter int PAD_X      = 630,
  parameter int PAD_H      = 70,
  parameter int SERVE_WAIT = 60,
  parameter int LIVES      = 3
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [11:0] pad_y,
  input  logic [11:0] pix_x,
  input  logic [11:0] pix_y,
  output logic        ball,
  output logic [11:0] ball_x,
  output logic [11:0] ball_y,
  output logic [7:0]  score,
  output logic [1:0]  lives_left,
  output logic        miss,
  output logic        game_over,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, PLAY = 2'd2, OVER = 2'd3} state_t;

  localparam logic [11:0] X_CTR     = 12'((H_MAX - BALL_SZ) / 2);
  localparam logic [11:0] Y_CTR     = 12'((V_MAX - BALL_SZ) / 2);
  localparam logic [11:0] BSZ       = 12'(BALL_SZ);
  localparam logic [11:0] X_PAD     = 12'(PAD_X);
  localparam logic [11:0] X_HIT     = 12'(PAD_X - BALL_SZ);
  localparam logic [11:0] Y_BOT     = 12'(V_MAX - BALL_SZ);
  localparam logic [11:0] V_LIM     = 12'(V_MAX);
  localparam logic [5:0]  WAIT_LAST = 6'(SERVE_WAIT - 1);
  localparam logic [1:0]  LIVES_INI = 2'(LIVES);
  localparam logic [3:0]  STEP_INI  = 4'(STEP0);

  state_t      state, state_n;
  logic [11:0] bx_n, by_n;
  logic        dx_right, dy_down, dx_n, dy_n;
  logic [7:0]  score_n, score_inc;
  logic [1:0]  lives_n;
  logic [5:0]  wait_cnt, cnt_n;
  logic        miss_n;
  logic [3:0]  step;
  logic [11:0] step12;
  logic        pad_overlap, reach_pad;

`ifdef BALL_SPEEDUP_EN
  logic [3:0] step_q, step_n;
  assign step = step_q;
`else
  assign step = STEP_INI;
`endif

  assign step12      = {8'd0, step};
  assign score_inc   = score + 8'd1;
  assign reach_pad   = (ball_x + BSZ + step12) >= X_PAD;
  assign pad_overlap = (({1'b0, ball_y} + 13'(BALL_SZ)) > {1'b0, pad_y}) &&
                       ({1'b0, ball_y} < ({1'b0, pad_y} + 13'(PAD_H)));
  assign game_over   = (state == OVER);
  assign state_dbg   = state;

  // Next-state, motion and collision resolution; X and Y are independent.
  always_comb begin
    state_n = state;
    bx_n    = ball_x;
    by_n    = ball_y;
    dx_n    = dx_right;
    dy_n    = dy_down;
    score_n = score;
    lives_n = lives_left;
    cnt_n   = wait_cnt;
    miss_n  = 1'b0;
`ifdef BALL_SPEEDUP_EN
    step_n  = step_q;
`endif
    case (state)
      IDLE: begin
        bx_n  = X_CTR;
        by_n  = Y_CTR;
        dx_n  = 1'b1;
        dy_n  = 1'b1;
        cnt_n = 6'd0;
        if (start) begin
          score_n = 8'd0;
          lives_n = LIVES_INI;
          state_n = SERVE;
`ifdef BALL_SPEEDUP_EN
          step_n  = STEP_INI;
`endif
        end
      end
      SERVE: begin
        if (!start) begin
          state_n = IDLE;
        end else if (frame_tick) begin
          if (wait_cnt == WAIT_LAST) begin
            cnt_n   = 6'd0;
            state_n = PLAY;
          end else begin
            cnt_n = wait_cnt + 6'd1;
          end
        end
      end
      PLAY: begin
        if (!start) begin
          state_n = IDLE;
        end else if (frame_tick) begin
          if (!dy_down) begin
            if (ball_y < step12) begin
              by_n = 12'd0;
              dy_n = 1'b1;
            end else begin
              by_n = ball_y - step12;
            end
          end else if ((ball_y + BSZ + step12) > V_LIM) begin
            by_n = Y_BOT;
            dy_n = 1'b0;
          end else begin
            by_n = ball_y + step12;
          end
          if (!dx_right) begin
            if (ball_x < step12) begin
              bx_n = 12'd0;
              dx_n = 1'b1;
            end else begin
              bx_n = ball_x - step12;
            end
          end else if (!reach_pad) begin
            bx_n = ball_x + step12;
          end else if (pad_overlap) begin
            bx_n = X_HIT;
            dx_n = 1'b0;
            if (score != 8'hFF) begin
              score_n = score_inc;
`ifdef BALL_SPEEDUP_EN
              if ((score_inc[1:0] == 2'b00) && (step_q < 4'd8)) step_n = step_q + 4'd1;
`endif
            end
          end else begin
            miss_n  = 1'b1;
            lives_n = lives_left - 2'd1;
            if (lives_left == 2'd1) begin
              // Game over: the ball stays where it was when the miss happened.
              state_n = OVER;
              bx_n    = ball_x;
              by_n    = ball_y;
            end else begin
              state_n = SERVE;
              bx_n    = X_CTR;
              by_n    = Y_CTR;
              dx_n    = 1'b1;
`ifdef BALL_SPEEDUP_EN
              step_n  = STEP_INI;
`endif
            end
          end
        end
      end
      OVER: begin
        if (!start) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers; sys_rst_n is an active-high synchronous reset.
  always_ff @(posedge vga_clk) begin
    if (sys_rst_n) begin
      state      <= IDLE;
      ball_x     <= X_CTR;
      ball_y     <= Y_CTR;
      dx_right   <= 1'b1;
      dy_down    <= 1'b1;
      score      <= 8'd0;
      lives_left <= LIVES_INI;
      wait_cnt   <= 6'd0;
      miss       <= 1'b0;
`ifdef BALL_SPEEDUP_EN
      step_q     <= STEP_INI;
`endif
    end else begin
      state      <= state_n;
      ball_x     <= bx_n;
      ball_y     <= by_n;
      dx_right   <= dx_n;
      dy_down    <= dy_n;
      score      <= score_n;
      lives_left <= lives_n;
      wait_cnt   <= cnt_n;
      miss       <= miss_n;
`ifdef BALL_SPEEDUP_EN
      step_q     <= step_n;
`endif
    end
  end

  // Registered pixel flag: half-open box [ball, ball+BALL_SZ) on both axes.
  always_ff @(posedge vga_clk) begin
    if (sys_rst_n) begin
      ball <= 1'b0;
    end else begin
      ball <= (pix_x >= ball_x) && (pix_x < (ball_x + BSZ)) &&
              (pix_y >= ball_y) && (pix_y < (ball_y + BSZ));
    end
  end

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine (default build, BALL_SPEEDUP_EN undefined).
module tb_ball_engine;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic        start = 1'b0;
  logic        frame_tick = 1'b0;
  logic [11:0] pad_y = 12'd0;
  logic [11:0] pix_x = 12'd0;
  logic [11:0] pix_y = 12'd0;
  logic        ball;
  logic [11:0] ball_x, ball_y;
  logic [7:0]  score;
  logic [1:0]  lives_left;
  logic        miss;
  logic        game_over;
  logic [1:0]  state_dbg;

  int n_pass  = 0;
  int n_total = 0;
  logic last_miss = 1'b0;

  localparam logic [1:0] S_IDLE = 2'd0, S_SERVE = 2'd1, S_PLAY = 2'd2, S_OVER = 2'd3;

  // Clock / reset block
  always #5 vga_clk = ~vga_clk;

  ball_engine dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .start(start), .frame_tick(frame_tick),
    .pad_y(pad_y), .pix_x(pix_x), .pix_y(pix_y), .ball(ball), .ball_x(ball_x),
    .ball_y(ball_y), .score(score), .lives_left(lives_left), .miss(miss),
    .game_over(game_over), .state_dbg(state_dbg)
  );

  // Driver: one frame_tick pulse then one quiet cycle; miss sampled in between.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(negedge vga_clk);
      frame_tick = 1'b0;
      last_miss = miss;
      @(negedge vga_clk);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b1;
    repeat (3) @(negedge vga_clk);
    n_total++; if (ball_x !== 12'd316) $display("FAIL reset_ball_x got %0d exp 316", ball_x); else n_pass++;
    n_total++; if (ball_y !== 12'd236) $display("FAIL reset_ball_y got %0d exp 236", ball_y); else n_pass++;
    n_total++; if (score !== 8'd0) $display("FAIL reset_score got %0d exp 0", score); else n_pass++;
    n_total++; if (lives_left !== 2'd3) $display("FAIL reset_lives got %0d exp 3", lives_left); else n_pass++;
    n_total++; if ({ball, miss, game_over} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {ball, miss, game_over}); else n_pass++;
    n_total++; if (state_dbg !== S_IDLE) $display("FAIL reset_state got %0d exp 0", state_dbg); else n_pass++;
    sys_rst_n = 1'b0;
    @(negedge vga_clk);
  endtask

  task automatic test_pixel();
    logic [11:0] px [6];
    logic [11:0] py [6];
    logic        ex [6];
    px = '{12'd316, 12'd323, 12'd324, 12'd316, 12'd315, 12'd320};
    py = '{12'd236, 12'd243, 12'd236, 12'd244, 12'd240, 12'd240};
    ex = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      pix_x = px[i];
      pix_y = py[i];
      @(negedge vga_clk);
      n_total++;
      if (ball !== ex[i]) $display("FAIL pixel_%0d (%0d,%0d) got %b exp %b", i, px[i], py[i], ball, ex[i]);
      else n_pass++;
    end
  endtask

  task automatic test_serve();
    start = 1'b1;
    @(negedge vga_clk);
    n_total++; if (state_dbg !== S_SERVE) $display("FAIL serve_enter got %0d exp 1", state_dbg); else n_pass++;
    tick_n(59);
    n_total++; if (state_dbg !== S_SERVE) $display("FAIL serve_59 got %0d exp 1", state_dbg); else n_pass++;
    tick_n(1);
    n_total++; if (state_dbg !== S_PLAY) $display("FAIL serve_60 got %0d exp 2", state_dbg); else n_pass++;
    n_total++; if ({ball_x, ball_y} !== {12'd316, 12'd236}) $display("FAIL play_start got (%0d,%0d) exp (316,236)", ball_x, ball_y); else n_pass++;
    tick_n(1);
    n_total++; if ({ball_x, ball_y} !== {12'd320, 12'd240}) $display("FAIL play_t1 got (%0d,%0d) exp (320,240)", ball_x, ball_y); else n_pass++;
  endtask

  task automatic test_bottom_wall();
    tick_n(58);
    n_total++; if ({ball_x, ball_y} !== {12'd552, 12'd472}) $display("FAIL bottom_t59 got (%0d,%0d) exp (552,472)", ball_x, ball_y); else n_pass++;
    tick_n(1);
    n_total++; if ({ball_x, ball_y} !== {12'd556, 12'd472}) $display("FAIL bottom_clamp got (%0d,%0d) exp (556,472)", ball_x, ball_y); else n_pass++;
    tick_n(1);
    n_total++; if ({ball_x, ball_y} !== {12'd560, 12'd468}) $display("FAIL bottom_up got (%0d,%0d) exp (560,468)", ball_x, ball_y); else n_pass++;
  endtask

  task automatic test_paddle_hit();
    pad_y = 12'd360;
    tick_n(14);
    n_total++; if ({ball_x, ball_y} !== {12'd616, 12'd412}) $display("FAIL pad_t75 got (%0d,%0d) exp (616,412)", ball_x, ball_y); else n_pass++;
    tick_n(1);
    n_total++; if ({ball_x, ball_y, score} !== {12'd620, 12'd408, 8'd0}) $display("FAIL pad_t76 got (%0d,%0d,%0d) exp (620,408,0)", ball_x, ball_y, score); else n_pass++;
    tick_n(1);
    n_total++; if ({ball_x, ball_y, score} !== {12'd622, 12'd404, 8'd1}) $display("FAIL pad_hit got (%0d,%0d,%0d) exp (622,404,1)", ball_x, ball_y, score); else n_pass++;
    n_total++; if (last_miss !== 1'b0) $display("FAIL pad_no_miss got %b exp 0", last_miss); else n_pass++;
    tick_n(1);
    n_total++; if ({ball_x, ball_y} !== {12'd618, 12'd400}) $display("FAIL pad_left got (%0d,%0d) exp (618,400)", ball_x, ball_y); else n_pass++;
  endtask

  task automatic test_top_wall();
    tick_n(100);
    n_total++; if ({ball_x, ball_y} !== {12'd218, 12'd0}) $display("FAIL top_reach got (%0d,%0d) exp (218,0)", ball_x, ball_y); else n_pass++;
    tick_n(1);
    n_total++; if ({ball_x, ball_y} !== {12'd214, 12'd0}) $display("FAIL top_clamp got (%0d,%0d) exp (214,0)", ball_x, ball_y); else n_pass++;
    tick_n(1);
    n_total++; if ({ball_x, ball_y} !== {12'd210, 12'd4}) $display("FAIL top_down got (%0d,%0d) exp (210,4)", ball_x, ball_y); else n_pass++;
  endtask

  task automatic test_left_wall();
    tick_n(52);
    n_total++; if ({ball_x, ball_y} !== {12'd2, 12'd212}) $display("FAIL left_near got (%0d,%0d) exp (2,212)", ball_x, ball_y); else n_pass++;
    tick_n(1);
    n_total++; if ({ball_x, ball_y} !== {12'd0, 12'd216}) $display("FAIL left_clamp got (%0d,%0d) exp (0,216)", ball_x, ball_y); else n_pass++;
    tick_n(1);
    n_total++; if ({ball_x, ball_y, score} !== {12'd4, 12'd220, 8'd1}) $display("FAIL left_right got (%0d,%0d,%0d) exp (4,220,1)", ball_x, ball_y, score); else n_pass++;
  endtask

  task automatic test_start_low();
    start = 1'b0;
    @(negedge vga_clk);
    n_total++; if (state_dbg !== S_IDLE) $display("FAIL stop_state got %0d exp 0", state_dbg); else n_pass++;
    n_total++; if (score !== 8'd1) $display("FAIL stop_score_held got %0d exp 1", score); else n_pass++;
    @(negedge vga_clk);
    n_total++; if ({ball_x, ball_y} !== {12'd316, 12'd236}) $display("FAIL stop_centre got (%0d,%0d) exp (316,236)", ball_x, ball_y); else n_pass++;
    start = 1'b1;
    @(negedge vga_clk);
    n_total++; if ({state_dbg, score, lives_left} !== {S_SERVE, 8'd0, 2'd3}) $display("FAIL restart got st=%0d sc=%0d lv=%0d exp st=1 sc=0 lv=3", state_dbg, score, lives_left); else n_pass++;
  endtask

  task automatic test_miss();
    logic [1:0] exp_lives [3];
    exp_lives = '{2'd2, 2'd1, 2'd0};
    pad_y = 12'd200;
    for (int g = 0; g < 3; g++) begin
      tick_n(60);
      tick_n(76);
      n_total++; if ({ball_x, last_miss} !== {12'd620, 1'b0}) $display("FAIL miss_pre_%0d got x=%0d m=%b exp x=620 m=0", g, ball_x, last_miss); else n_pass++;
      tick_n(1);
      n_total++; if (last_miss !== 1'b1) $display("FAIL miss_pulse_%0d got %b exp 1", g, last_miss); else n_pass++;
      n_total++; if (miss !== 1'b0) $display("FAIL miss_width_%0d got %b exp 0", g, miss); else n_pass++;
      n_total++; if (lives_left !== exp_lives[g]) $display("FAIL miss_lives_%0d got %0d exp %0d", g, lives_left, exp_lives[g]); else n_pass++;
      if (g < 2) begin
        n_total++; if ({state_dbg, ball_x, ball_y, game_over} !== {S_SERVE, 12'd316, 12'd236, 1'b0}) $display("FAIL miss_reserve_%0d got st=%0d (%0d,%0d) go=%b exp st=1 (316,236) go=0", g, state_dbg, ball_x, ball_y, game_over); else n_pass++;
      end else begin
        n_total++; if ({state_dbg, game_over} !== {S_OVER, 1'b1}) $display("FAIL game_over got st=%0d go=%b exp st=3 go=1", state_dbg, game_over); else n_pass++;
      end
    end
    tick_n(3);
    n_total++; if ({state_dbg, game_over, lives_left} !== {S_OVER, 1'b1, 2'd0}) $display("FAIL over_hold got st=%0d go=%b lv=%0d exp st=3 go=1 lv=0", state_dbg, game_over, lives_left); else n_pass++;
    start = 1'b0;
    @(negedge vga_clk);
    n_total++; if ({state_dbg, game_over} !== {S_IDLE, 1'b0}) $display("FAIL over_exit got st=%0d go=%b exp st=0 go=0", state_dbg, game_over); else n_pass++;
  endtask

  task automatic test_reset_mid_play();
    pad_y = 12'd360;
    start = 1'b1;
    @(negedge vga_clk);
    tick_n(60);
    tick_n(5);
    n_total++; if ({state_dbg, ball_x, ball_y} !== {S_PLAY, 12'd336, 12'd256}) $display("FAIL midplay_pos got st=%0d (%0d,%0d) exp st=2 (336,256)", state_dbg, ball_x, ball_y); else n_pass++;
    sys_rst_n = 1'b1;
    frame_tick = 1'b1;
    @(negedge vga_clk);
    frame_tick = 1'b0;
    n_total++; if ({state_dbg, ball_x, ball_y} !== {S_IDLE, 12'd316, 12'd236}) $display("FAIL midreset_pos got st=%0d (%0d,%0d) exp st=0 (316,236)", state_dbg, ball_x, ball_y); else n_pass++;
    n_total++; if ({score, lives_left, miss, game_over, ball} !== {8'd0, 2'd3, 3'b000}) $display("FAIL midreset_outs got sc=%0d lv=%0d m=%b go=%b b=%b exp 0 3 0 0 0", score, lives_left, miss, game_over, ball); else n_pass++;
    start = 1'b0;
    sys_rst_n = 1'b0;
    @(negedge vga_clk);
  endtask

  initial begin
    @(negedge vga_clk);
    test_reset();
    test_pixel();
    test_serve();
    test_bottom_wall();
    test_paddle_hit();
    test_top_wall();
    test_left_wall();
    test_start_low();
    test_miss();
    test_reset_mid_play();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
